// File: rtl/mul_acc_pkg.sv
// Shared types and constants for the product accumulator.
package mul_acc_pkg;

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LEN   = 4;
    localparam int DEF_OUT_W = 16;

    // One guard bit on top of log2(LEN) growth keeps the signed sum exact.
    function automatic int acc_width(input int width, input int len);
        return 2 * width + $clog2(len) + 1;
    endfunction

endpackage

// File: rtl/mul_accumulator_if.sv
// Product-in / sum-out valid-ready bundle between multiplier, accumulator and next stage.
interface mul_accumulator_if #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 16
);
    logic                        valid_in;
    logic signed [2*WIDTH-1:0]   product;
    logic                        ready_in;
    logic                        valid_out;
    logic signed [OUT_W-1:0]     sum;
    logic                        ready_out;
    logic                        ovf;

    modport slave (
        input  valid_in, product, ready_out,
        output ready_in, valid_out, sum, ovf
    );

    modport master (
        output valid_in, product, ready_out,
        input  ready_in, valid_out, sum, ovf
    );
endinterface

// File: rtl/mul_accumulator_acc_clip.sv
// Narrows the full-precision accumulator to OUT_W bits: wraps by default,
// saturates with an overflow flag when MUL_ACC_SAT_EN is defined.
module acc_clip #(
    parameter int ACC_W = 19,
    parameter int OUT_W = 16
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [OUT_W-1:0] sum_n,
    output logic                    ovf_n
);

    generate
        if (OUT_W >= ACC_W) begin : g_wide
            assign sum_n = OUT_W'(i_acc);
            assign ovf_n = 1'b0;
        end else begin : g_narrow
`ifdef MUL_ACC_SAT_EN
            // Value fits when all bits from the OUT_W sign bit upward agree.
            function automatic logic fits(input logic signed [ACC_W-1:0] v);
                logic [ACC_W-OUT_W:0] hi;
                hi = v[ACC_W-1:OUT_W-1];
                return (&hi) || (~|hi);
            endfunction

            function automatic logic signed [OUT_W-1:0] sat_clip(input logic signed [ACC_W-1:0] v);
                if (fits(v))
                    return v[OUT_W-1:0];
                else if (v[ACC_W-1])
                    return {1'b1, {(OUT_W-1){1'b0}}};
                else
                    return {1'b0, {(OUT_W-1){1'b1}}};
            endfunction

            assign sum_n = sat_clip(i_acc);
            assign ovf_n = ~fits(i_acc);
`else
            logic w_unused_hi;
            assign w_unused_hi = ^i_acc[ACC_W-1:OUT_W];
            assign sum_n       = i_acc[OUT_W-1:0];
            assign ovf_n       = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: rtl/mul_accumulator.sv
// Accumulates LEN signed products into one dot-product sum and hands it downstream.
// Optional saturation of the narrowed sum: define MUL_ACC_SAT_EN.
module mul_accumulator
    import mul_acc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN   = DEF_LEN,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic            clk,
    input  logic            rst,
    mul_accumulator_if.slave bus
);

    localparam int PW    = 2 * WIDTH;
    localparam int ACC_W = acc_width(WIDTH, LEN);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

    state_t                  r_state;
    state_t                  w_next_state;
    logic signed [ACC_W-1:0] r_acc;
    logic        [CNT_W-1:0] r_cnt;
    logic signed [OUT_W-1:0] r_sum;
    logic                    r_ovf;

    logic                    w_ready_in;
    logic                    w_valid_out;
    logic                    w_accept;
    logic                    w_last;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_acc_sum;
    logic signed [OUT_W-1:0] w_sum_n;
    logic                    w_ovf_n;

    assign w_accept   = bus.valid_in && w_ready_in;
    assign w_last     = (r_cnt == CNT_W'(LEN - 1));
    assign w_prod_ext = {{(ACC_W-PW){bus.product[PW-1]}}, bus.product};
    assign w_acc_sum  = r_acc + w_prod_ext;

    acc_clip #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_acc_clip (
        .i_acc (w_acc_sum),
        .sum_n (w_sum_n),
        .ovf_n (w_ovf_n)
    );

    always_comb begin
        w_next_state = r_state;
        w_ready_in   = 1'b0;
        w_valid_out  = 1'b0;
        case (r_state)
            ACCUM: begin
                w_ready_in = 1'b1;
                if (bus.valid_in && w_last)
                    w_next_state = OUTPUT;
            end
            OUTPUT: begin
                w_valid_out = 1'b1;
                if (bus.ready_out)
                    w_next_state = ACCUM;
            end
            default: w_next_state = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                if (w_last) begin
                    r_sum <= w_sum_n;
                    r_ovf <= w_ovf_n;
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_acc_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (w_valid_out && bus.ready_out) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.ready_in  = w_ready_in;
    assign bus.valid_out = w_valid_out;
    assign bus.sum       = r_sum;
    assign bus.ovf       = r_ovf;

endmodule
